// File: rtl/imem_loader.sv
// Boot-time loader: assembles big-endian 16-bit words from a byte stream, writes
// them to instruction memory from address 0, verifies an XOR checksum, then releases the CPU.
module imem_loader #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [7:0]  imem_waddr,
    output logic [15:0] imem_wdata,
    output logic        cpu_run,
    output logic        load_err,
    output logic [8:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t      state, state_nx;
    logic        armed;
    logic [7:0]  n_q, idx_q, hi_q, lo_q, csum_q;
    logic [8:0]  wcnt_q;
    logic [7:0]  last_idx;
    logic        acc;

    // armed keeps byte_ready low until the first edge after reset release
    assign byte_ready = armed && (state == S_IDLE || state == S_HI ||
                                  state == S_LO   || state == S_CSUM);
    assign acc        = byte_valid && byte_ready;
    assign last_idx   = n_q - 8'd1;   // N=0 encodes 256 words, so last index is 0xFF

    assign imem_we      = (state == S_WRITE);
    assign imem_waddr   = idx_q;
    assign imem_wdata   = {hi_q, lo_q};
    assign cpu_run      = (state == S_DONE);
    assign load_err     = (state == S_ERROR);
    assign words_loaded = wcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (reload) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (acc) state_nx = S_HI;
                S_HI:    if (acc) state_nx = S_LO;
                S_LO:    if (acc) state_nx = S_WRITE;
                S_WRITE: begin
                    if (idx_q == last_idx) state_nx = CHECK_EN ? S_CSUM : S_DONE;
                    else                   state_nx = S_HI;
                end
                S_CSUM:  if (acc) state_nx = (byte_data == csum_q) ? S_DONE : S_ERROR;
                S_DONE:  state_nx = S_DONE;
                S_ERROR: state_nx = S_ERROR;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            n_q    <= '0;
            idx_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            csum_q <= '0;
            wcnt_q <= '0;
        end else begin
            armed <= 1'b1;
            if (reload) begin
                idx_q  <= '0;
                csum_q <= '0;
                wcnt_q <= '0;
            end else begin
                case (state)
                    S_IDLE: if (acc) begin
                        n_q    <= byte_data;
                        csum_q <= byte_data;
                        idx_q  <= '0;
                    end
                    S_HI: if (acc) begin
                        hi_q   <= byte_data;
                        csum_q <= csum_q ^ byte_data;
                    end
                    S_LO: if (acc) begin
                        lo_q   <= byte_data;
                        csum_q <= csum_q ^ byte_data;
                    end
                    S_WRITE: begin
                        idx_q  <= idx_q + 8'd1;
                        wcnt_q <= wcnt_q + 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
